// File: rtl/bias_accum_stage_pkg.sv
// Shared definitions for the bias accumulate stage.
//   - default parameter values for the lane count and widths
//   - state_e : FSM state encoding (ACCUM -> BIAS -> OUT -> ACCUM)
//   - lane_lo : low bit index of a lane inside a packed lane bus
//   - sat_max / sat_min : saturation bounds of a signed w-bit lane
package bias_accum_stage_pkg;

  localparam int DEF_LANES  = 16;
  localparam int DEF_W      = 18;
  localparam int DEF_PASS_W = 8;
  localparam int DEF_ACC_W  = 26;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_BIAS  = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Lane i of a packed bus occupies [lane_lo(i,w) +: w].
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

  // Largest value representable in a signed w-bit lane.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a signed w-bit lane.
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/bias_accum_stage_sat_relu_lane.sv
// One lane of the bias / saturate / ReLU datapath. Purely combinational.
// Ports:
//   i_acc  [ACC_W-1:0] signed accumulated partial sum of the lane
//   i_bias [W-1:0]     signed bias constant of the lane
//   i_relu             1 = clamp negative results to zero
//   o_res  [W-1:0]     saturated, optionally rectified result
module bias_sat_relu_lane
  import bias_accum_stage_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [W-1:0]     i_bias,
  input  logic             i_relu,
  output logic [W-1:0]     o_res
);

  // The sum is one bit wider than the accumulator so acc + bias can never wrap.
  localparam logic signed [ACC_W:0] L_MAX = (ACC_W + 1)'(sat_max(W));
  localparam logic signed [ACC_W:0] L_MIN = (ACC_W + 1)'(sat_min(W));

  logic signed [ACC_W:0] w_sum;
  logic        [W-1:0]   w_sat;

  assign w_sum = $signed({i_acc[ACC_W-1], i_acc})
               + $signed({{(ACC_W + 1 - W){i_bias[W-1]}}, i_bias});

  always_comb begin
    w_sat = w_sum[W-1:0];
    if (w_sum > L_MAX) begin
      w_sat = L_MAX[W-1:0];
    end else if (w_sum < L_MIN) begin
      w_sat = L_MIN[W-1:0];
    end
  end

  // Saturation never changes the sign, so the sign bit of w_sat decides ReLU.
  assign o_res = (i_relu && w_sat[W-1]) ? '0 : w_sat;

endmodule

// File: rtl/bias_accum_stage.sv
// Bias accumulate stage: consumer end of the per-layer bias constant bus.
// Accumulates N_adder_tree lanes of adder-tree partial sums over a
// configurable number of passes, adds the per-lane bias, saturates to W bits
// and optionally rectifies.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_passes        beats per group (0 treated as 1), latched on first beat
//   cfg_relu          1 = clamp negative results, latched on first beat
//   bias              per-lane bias, lane i at [W*i +: W]
//   in_valid/in_ready partial-sum beat handshake, in_data lane packed
//   out_valid/out_ready result handshake, out_data lane packed
//   busy              group partially accumulated or result pending
//   dbg_state         current FSM state
//
// Handshake rule for both ports: a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer holds valid and data stable
// until that edge; ready may be low at any time and valid seen while ready
// is low is ignored (no transfer, no state change).
module bias_accum_stage
  import bias_accum_stage_pkg::*;
#(
  parameter int N_adder_tree = DEF_LANES,
  parameter int W            = DEF_W,
  parameter int PASS_W       = DEF_PASS_W,
  parameter int ACC_W        = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PASS_W-1:0]         cfg_passes,
  input  logic                      cfg_relu,
  input  logic [N_adder_tree*W-1:0] bias,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_adder_tree*W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_adder_tree*W-1:0] out_data,
  output logic                      busy,
  output state_e                    dbg_state
);

  state_e                              r_state;
  state_e                              w_next_state;
  logic [PASS_W-1:0]                   r_count;
  logic [PASS_W-1:0]                   r_passes;
  logic                                r_relu;
  logic [N_adder_tree-1:0][ACC_W-1:0]  r_acc;
  logic [N_adder_tree*W-1:0]           r_out_data;

  logic [N_adder_tree-1:0][ACC_W-1:0]  w_in_ext;
  logic [N_adder_tree-1:0][W-1:0]      w_lane_res;
  logic [PASS_W-1:0]                   w_cfg_passes_eff;
  logic [PASS_W-1:0]                   w_passes_cur;
  logic                                w_accept;
  logic                                w_last_beat;
  logic                                w_first_beat;
  logic                                w_out_done;

  // ---------------------------------------------------------------------
  // Beat bookkeeping
  // ---------------------------------------------------------------------
  assign w_cfg_passes_eff = (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
  assign w_first_beat     = (r_count == '0);
  // On the first beat the latched value is not written yet, so the live
  // configuration decides whether that beat already completes the group.
  assign w_passes_cur     = w_first_beat ? w_cfg_passes_eff : r_passes;
  assign w_accept         = in_valid && (r_state == ST_ACCUM);
  assign w_last_beat      = (({1'b0, r_count} + (PASS_W + 1)'(1)) == {1'b0, w_passes_cur});
  assign w_out_done       = (r_state == ST_OUT) && out_ready;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_ACCUM: if (w_accept && w_last_beat) w_next_state = ST_BIAS;
      ST_BIAS:  w_next_state = ST_OUT;
      ST_OUT:   if (out_ready) w_next_state = ST_ACCUM;
      default:  w_next_state = ST_ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------
  // Counter and group configuration
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_passes <= PASS_W'(1);
      r_relu   <= 1'b0;
    end else begin
      if (w_out_done) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + PASS_W'(1);
      end
      if (w_accept && w_first_beat) begin
        r_passes <= w_cfg_passes_eff;
        r_relu   <= cfg_relu;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Lanes: sign extension, accumulators and bias/saturate/ReLU
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < N_adder_tree; g++) begin : g_lane
    assign w_in_ext[g] = {{(ACC_W - W){in_data[lane_lo(g, W) + W - 1]}},
                          in_data[lane_lo(g, W) +: W]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc[g] <= '0;
      end else if (w_out_done) begin
        r_acc[g] <= '0;
      end else if (w_accept) begin
        // The first beat loads, so a stale accumulator can never leak in.
        r_acc[g] <= w_first_beat ? w_in_ext[g] : (r_acc[g] + w_in_ext[g]);
      end
    end

    bias_sat_relu_lane #(
      .W     (W),
      .ACC_W (ACC_W)
    ) u_lane (
      .i_acc  (r_acc[g]),
      .i_bias (bias[lane_lo(g, W) +: W]),
      .i_relu (r_relu),
      .o_res  (w_lane_res[g])
    );
  end

  // Result register: written only in BIAS, held through OUT and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
    end else if (r_state == ST_BIAS) begin
      r_out_data <= w_lane_res;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_OUT);
  assign out_data  = r_out_data;
  assign busy      = (r_count != '0) || (r_state != ST_ACCUM);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bias_accum_stage.sv
module tb_bias_accum_stage;
  import bias_accum_stage_pkg::*;

  localparam int N      = 16;
  localparam int W      = 18;
  localparam int PASS_W = 8;
  localparam int ACC_W  = 26;
  localparam int D      = N * W;
  localparam int LMAX   = 131071;
  localparam int LMIN   = -131072;

  typedef logic [D-1:0] vec_t;

  typedef struct {
    string name;
    int    passes;
    bit    relu;
    vec_t  bias;
    vec_t  beats[3];
    vec_t  exp;
  } vec_rec_t;

  // ---------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic [PASS_W-1:0] cfg_passes;
  logic              cfg_relu;
  vec_t              bias;
  logic              in_valid;
  logic              in_ready;
  vec_t              in_data;
  logic              out_valid;
  logic              out_ready;
  vec_t              out_data;
  logic              busy;
  state_e            dbg_state;

  always #5 clk = ~clk;

  bias_accum_stage #(
    .N_adder_tree (N),
    .W            (W),
    .PASS_W       (PASS_W),
    .ACC_W        (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_passes (cfg_passes),
    .cfg_relu   (cfg_relu),
    .bias       (bias),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------
  // Helpers and reference model
  // ---------------------------------------------------------------------
  function automatic vec_t set_lane(input vec_t v, input int l, input int val);
    vec_t r;
    r = v;
    r[l*W +: W] = W'(val);
    return r;
  endfunction

  function automatic int get_lane(input vec_t v, input int l);
    logic signed [W-1:0] x;
    x = v[l*W +: W];
    return int'(x);
  endfunction

  function automatic int rand_lane();
    return int'($urandom_range(0, 2 * LMAX + 1)) + LMIN;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v = '0;
    for (int l = 0; l < N; l++) v = set_lane(v, l, rand_lane());
    return v;
  endfunction

  // Plain integer arithmetic: sum the beats, add bias, clamp, rectify.
  function automatic vec_t model(input int passes, input bit relu,
                                 input vec_t bias_v, input vec_t beats[8]);
    vec_t r = '0;
    int   np = (passes == 0) ? 1 : passes;
    for (int l = 0; l < N; l++) begin
      longint s = 0;
      for (int b = 0; b < np; b++) s += get_lane(beats[b], l);
      s += get_lane(bias_v, l);
      if (s > LMAX) s = LMAX;
      if (s < LMIN) s = LMIN;
      if (relu && s < 0) s = 0;
      r = set_lane(r, l, int'(s));
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  vec_t exp_q[$];

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // Presents a beat at the falling edge and returns #1 after the rising
  // edge that accepted it.
  task automatic send_beat(input string name, input vec_t d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk({name, "_in_ready_timeout"}, vec_t'(in_ready), vec_t'(1'b1));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends one group, checks the 2-cycle latency, compares against the head
  // of the scoreboard, holds out_ready low for ready_delay cycles and
  // completes the handshake.
  task automatic run_group(input string name, input int passes, input bit relu,
                           input vec_t bias_v, input vec_t beats[8],
                           input int ready_delay);
    int   np = (passes == 0) ? 1 : passes;
    vec_t exp;
    cfg_passes = PASS_W'(passes);
    cfg_relu   = relu;
    bias       = bias_v;
    for (int b = 0; b < np; b++) send_beat(name, beats[b]);
    chk({name, "_valid_t1"}, vec_t'(out_valid), vec_t'(1'b0));
    @(posedge clk);
    #1;
    chk({name, "_valid_t2"}, vec_t'(out_valid), vec_t'(1'b1));
    exp = exp_q.pop_front();
    chk({name, "_data"}, out_data, exp);
    for (int c = 0; c < ready_delay; c++) begin
      @(posedge clk);
      #1;
      chk({name, "_hold_valid"}, vec_t'(out_valid), vec_t'(1'b1));
      chk({name, "_hold_data"}, out_data, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_valid_clr"}, vec_t'(out_valid), vec_t'(1'b0));
    chk({name, "_idle"}, vec_t'({busy, in_ready}), vec_t'(2'b01));
  endtask

  // ---------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------
  vec_rec_t tv[5];
  vec_t     bt[8];
  vec_t     v, hold;

  initial begin
    rst_n      = 1'b0;
    cfg_passes = '0;
    cfg_relu   = 1'b0;
    bias       = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;

    // Directed vectors; expected values are written out by hand.
    foreach (tv[i]) begin
      tv[i].bias = '0;
      tv[i].exp  = '0;
      for (int b = 0; b < 3; b++) tv[i].beats[b] = '0;
    end
    tv[0].name = "basic";    tv[0].passes = 1; tv[0].relu = 1'b0;
    tv[0].bias     = set_lane('0, 0, -5964);
    tv[0].beats[0] = set_lane('0, 0, 10000);
    tv[0].exp      = set_lane('0, 0, 4036);

    tv[1].name = "sat3";     tv[1].passes = 3; tv[1].relu = 1'b0;
    tv[1].bias     = set_lane(set_lane('0, 1, 3564), 2, -5964);
    tv[1].beats[0] = set_lane(set_lane('0, 1, 100000), 2, -131072);
    tv[1].beats[1] = set_lane(set_lane('0, 1, 100000), 2, -131072);
    tv[1].beats[2] = set_lane(set_lane('0, 1, 100000), 2, 0);
    tv[1].exp      = set_lane(set_lane('0, 1, 131071), 2, -131072);

    tv[2].name = "relu";     tv[2].passes = 1; tv[2].relu = 1'b1;
    tv[2].bias     = set_lane(set_lane('0, 0, -5964), 1, 3564);
    tv[2].beats[0] = set_lane(set_lane('0, 0, 1000), 1, 1000);
    tv[2].exp      = set_lane(set_lane('0, 0, 0), 1, 4564);

    tv[3].name = "passes0";  tv[3].passes = 0; tv[3].relu = 1'b0;
    tv[3].bias     = set_lane('0, 15, 131071);
    tv[3].beats[0] = set_lane(set_lane('0, 3, -500), 15, 131071);
    tv[3].exp      = set_lane(set_lane('0, 3, -500), 15, 131071);

    tv[4].name = "relu_sat"; tv[4].passes = 2; tv[4].relu = 1'b1;
    tv[4].bias     = set_lane(set_lane('0, 0, -131072), 5, -20000);
    tv[4].beats[0] = set_lane(set_lane('0, 0, -131072), 5, 50000);
    tv[4].beats[1] = set_lane(set_lane('0, 0, -131072), 5, 60000);
    tv[4].exp      = set_lane(set_lane('0, 0, 0), 5, 90000);

    // Reset values while rst_n is held low, before any clock edge.
    #2;
    chk("rst_in_ready",  vec_t'(in_ready),  vec_t'(1'b1));
    chk("rst_out_valid", vec_t'(out_valid), vec_t'(1'b0));
    chk("rst_out_data",  out_data,          '0);
    chk("rst_busy",      vec_t'(busy),      vec_t'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven directed groups.
    foreach (tv[i]) begin
      for (int b = 0; b < 8; b++) bt[b] = (b < 3) ? tv[i].beats[b] : '0;
      exp_q.push_back(tv[i].exp);
      run_group(tv[i].name, tv[i].passes, tv[i].relu, tv[i].bias, bt, i % 2);
    end

    // Configuration changed after the first beat must not affect the group.
    cfg_passes = 8'd2;
    cfg_relu   = 1'b0;
    bias       = '0;
    send_beat("cfg_mid", set_lane('0, 0, -3000));
    chk("cfg_mid_busy", vec_t'({busy, in_ready}), vec_t'(2'b11));
    cfg_passes = 8'd1;
    cfg_relu   = 1'b1;
    send_beat("cfg_mid", set_lane('0, 0, -1000));
    chk("cfg_mid_valid_t1", vec_t'(out_valid), vec_t'(1'b0));
    @(posedge clk);
    #1;
    chk("cfg_mid_data", out_data, set_lane('0, 0, -4000));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Backpressure: a pending result blocks new beats.
    for (int b = 0; b < 8; b++) bt[b] = '0;
    bt[0] = set_lane(set_lane('0, 0, 123), 7, -77);
    cfg_passes = 8'd1;
    cfg_relu   = 1'b0;
    bias       = '0;
    send_beat("bp", bt[0]);
    @(posedge clk);
    #1;
    hold = set_lane(set_lane('0, 0, 123), 7, -77);
    chk("bp_data", out_data, hold);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = set_lane('0, 0, 999);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", out_data, hold);
      chk("bp_hold_ctl", vec_t'({out_valid, in_ready, busy}), vec_t'(3'b101));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release", vec_t'({out_valid, in_ready, busy}), vec_t'(3'b010));
    chk("bp_data_kept", out_data, hold);
    bt[0] = set_lane('0, 0, 5);
    exp_q.push_back(set_lane('0, 0, 5));
    run_group("bp_next", 1, 1'b0, '0, bt, 0);

    // Reset in the middle of a group.
    cfg_passes = 8'd3;
    cfg_relu   = 1'b0;
    bias       = '0;
    v = '0;
    for (int l = 0; l < N; l++) v = set_lane(v, l, 7777);
    send_beat("rst_mid", v);
    send_beat("rst_mid", v);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy",  vec_t'(busy),      vec_t'(1'b0));
    chk("rst_mid_ready", vec_t'(in_ready),  vec_t'(1'b1));
    chk("rst_mid_valid", vec_t'(out_valid), vec_t'(1'b0));
    chk("rst_mid_data",  out_data,          '0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '0;
    for (int l = 0; l < N; l++) v = set_lane(v, l, 1);
    for (int b = 0; b < 8; b++) bt[b] = (b < 3) ? v : '0;
    v = '0;
    for (int l = 0; l < N; l++) v = set_lane(v, l, 3);
    exp_q.push_back(v);
    run_group("rst_mid_next", 3, 1'b0, '0, bt, 0);

    // Randomized groups checked against the reference model.
    for (int g = 0; g < 25; g++) begin
      int   p;
      bit   r;
      vec_t bv;
      p  = int'($urandom_range(0, 4));
      r  = 1'($urandom_range(0, 1));
      bv = rand_vec();
      for (int b = 0; b < 8; b++) bt[b] = rand_vec();
      exp_q.push_back(model(p, r, bv, bt));
      run_group("rand", p, r, bv, bt, int'($urandom_range(0, 3)));
    end

    chk("scoreboard_empty", vec_t'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bias_accum_stage.md
Name: bias_accum_stage

Overview:
- Consumer end of the per-layer bias constant bus.
- Accumulates N_adder_tree lanes of adder-tree partial sums over a configurable number of passes (input-channel groups), adds the per-lane bias constant, saturates to W bits and applies optional ReLU.
- Sits between the adder-tree output of a layer and the activation writeback.
- Bias comes from a BIAS_layer* constant module wired to the bias port.

Parameters:
- N_adder_tree, 16, number of parallel lanes.
- W, 18, lane width of partial sums, bias and outputs (signed two's complement, same fixed-point format).
- PASS_W, 8, width of pass-count configuration.
- ACC_W, 26, accumulator width per lane. Must satisfy ACC_W >= W+PASS_W, so the accumulator never overflows.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_passes  in  PASS_W  partial sums per output group. Sampled on the first accepted beat of a group; 0 is treated as 1.
- cfg_relu  in  1  1 = clamp negative results to 0. Sampled with cfg_passes.
- bias  in  N_adder_tree*W  per-lane bias; lane i is bias[W*(i+1)-1:W*i]. Static while a group is in flight.
- in_valid  in  1  partial-sum beat valid
- in_ready  out  1  stage accepts a beat
- in_data  in  N_adder_tree*W  signed partial sums, same lane packing as bias
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N_adder_tree*W  saturated, optionally rectified results, same lane packing
- busy  out  1  a group is partially accumulated or a result is pending

Behaviour:
- Reset (rst_n low, asynchronous):
  - State ACCUM; all accumulators and the pass counter are 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
- States: ACCUM, BIAS, OUT.
- ACCUM:
  - in_ready=1. On in_valid&in_ready, each lane adds its sign-extended in_data to its accumulator (count==0 loads instead of adding) and the counter increments.
  - When the accepted beat is beat number passes_latched, go to BIAS. With passes=1 the first beat both loads and completes.
- BIAS (exactly 1 cycle):
  - in_ready=0.
  - Per lane, r = acc + sign-extended bias.
  - Saturate r to [-2^(W-1), 2^(W-1)-1], i.e. [-131072, 131071] for W=18.
  - If relu_latched and the result is negative, use 0.
  - Register the result into out_data, set out_valid=1, go to OUT.
- OUT:
  - in_ready=0. out_valid and out_data are held stable until out_ready.
  - On out_valid&out_ready: out_valid=0 next cycle, accumulators and counter cleared, go to ACCUM.
  - out_data keeps its last value after the handshake; only out_valid qualifies it.
- Latency: final input beat accepted at cycle t gives out_valid=1 at t+2.
- Throughput: one group per passes+2 cycles when out_ready is held high.
- No bubble removal: a new group cannot start while OUT is pending (in_ready=0 in BIAS/OUT).
- Configuration: cfg changes mid-group have no effect until the next group's first beat.
- busy = (count!=0) or state!=ACCUM.
- in_valid while in_ready=0 is ignored; the upstream must hold it.

Decomposition:
- Shared package: lane slice helper (lane index to bit range), saturation constants SAT_MAX/SAT_MIN derived from W, and the state enum.
- One natural sub-module: bias_sat_relu_lane. It is combinational and covers one lane: acc + bias, saturate, ReLU. It is instantiated N_adder_tree times in a generate loop. The FSM, counter and accumulators stay in the top.

Test Plan:
- Reset: assert rst_n=0 mid-run, then release → in_ready=1, out_valid=0, out_data=0, busy=0 immediately on assertion, without waiting for a clock edge.
- passes=1, relu=0, lane0 in=10000, bias lane0=-5964 → out lane0=4036 with out_valid exactly 2 cycles after the accepted beat.
- Saturation, passes=3, lane1 bias=3564:
  - lane1 beats 100000, 100000, 100000 → 131071.
  - lane2 beats -131072, -131072, 0 with bias -5964 → -131072.
- ReLU: relu=1, lane0 in=1000, bias=-5964 → 0; lane1 in=1000, bias=3564 → 4564 (positive lanes unaffected).
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → out_data stable, in_ready=0, no beat consumed; out_ready=1 → handshake, then the next group accumulates from zero.
- Reset mid-group: 2 of 3 beats accepted, pulse rst_n low → counter/accumulators cleared; the next 3 beats of 1 each plus bias 0 → out=3.
